// File: rtl/serial_rx_pkg.sv
// rtl/serial_rx_pkg.sv - shared types and constants for the clock-synchronous serial receiver
package serial_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_ERR
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  function automatic int frame_cycles(input int data_w, input int parity_mode, input int stop_bits);
    return 1 + data_w + ((parity_mode != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/serial_rx_param.sv
// rtl/serial_rx_param.sv - one-bit-per-clock serial deserialiser with one-entry valid/ready holding register
module serial_rx_param
  import serial_rx_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_perr,
  output logic              frm_err,
  output logic              ovr_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  rx_state_t          r_state;
  rx_state_t          w_state_next;
  logic [DATA_W-1:0]  r_shift;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_acc;
  logic               r_perr;
  logic               r_done;
  logic               r_frm_err;
  logic               r_ovr_err;
  logic [DATA_W-1:0]  r_rx_data;
  logic               r_rx_valid;
  logic               r_rx_perr;

  logic               w_start;
  logic               w_sample_data;
  logic               w_sample_par;
  logic               w_cnt_clr;
  logic               w_cnt_inc;
  logic               w_frame_ok;
  logic               w_frame_bad;
  logic               w_perr_next;

  assign w_perr_next = (PARITY_MODE == PAR_ODD) ? ~(r_acc ^ in) : (r_acc ^ in);

  always_comb begin
    w_state_next  = r_state;
    w_start       = 1'b0;
    w_sample_data = 1'b0;
    w_sample_par  = 1'b0;
    w_cnt_clr     = 1'b0;
    w_cnt_inc     = 1'b0;
    w_frame_ok    = 1'b0;
    w_frame_bad   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!in) begin
          w_start      = 1'b1;
          w_cnt_clr    = 1'b1;
          w_state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        w_sample_data = 1'b1;
        if (r_cnt == LAST_DATA) begin
          w_cnt_clr    = 1'b1;
          w_state_next = (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      ST_PARITY: begin
        w_sample_par = 1'b1;
        w_state_next = ST_STOP;
      end
      ST_STOP: begin
        // a single low stop sample kills the frame, no need to wait for the rest
        if (!in) begin
          w_frame_bad  = 1'b1;
          w_cnt_clr    = 1'b1;
          w_state_next = ST_ERR;
        end else if (r_cnt == LAST_STOP) begin
          w_frame_ok   = 1'b1;
          w_cnt_clr    = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      ST_ERR: begin
        if (in) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_acc   <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_start) begin
        r_acc  <= 1'b0;
        r_perr <= 1'b0;
      end else if (w_sample_data) begin
        r_shift <= {in, r_shift[DATA_W-1:1]};
        r_acc   <= r_acc ^ in;
      end else if (w_sample_par) begin
        r_perr <= w_perr_next;
      end
    end
  end

  // r_shift/r_perr stay put for the cycle after the last stop bit, so the
  // holding register loads one edge later while a new start bit may be sampled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done     <= 1'b0;
      r_frm_err  <= 1'b0;
      r_ovr_err  <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_perr  <= 1'b0;
    end else begin
      r_done    <= w_frame_ok;
      r_frm_err <= w_frame_bad;
      r_ovr_err <= 1'b0;
      if (r_done) begin
        if (!r_rx_valid || rx_ready) begin
          r_rx_data  <= r_shift;
          r_rx_perr  <= r_perr;
          r_rx_valid <= 1'b1;
        end else begin
          r_ovr_err <= 1'b1;
        end
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign rx_perr  = r_rx_perr;
  assign frm_err  = r_frm_err;
  assign ovr_err  = r_ovr_err;
  assign busy     = (r_state != ST_IDLE);

endmodule
